// File: rtl/scmp_bus_if.sv
// Signal bundle between the microcode sequencer, the SC/MP bus controller and the shared system bus.
// The master view belongs to the controller; the slave view is the sequencer/bus environment.
interface scmp_bus_if;
    logic        cyc_req;
    logic        cyc_wr;
    logic [15:0] cyc_addr;
    logic [7:0]  cyc_wdata;
    logic        f_r;
    logic        f_i;
    logic        f_d;
    logic        f_h;
    logic        cyc_ack;
    logic [7:0]  cyc_rdata;
    logic        stall;
    logic        bus_BREQ;
    logic        bus_ENIN;
    logic        bus_ENOUT;
    logic        bus_NHOLD;
    logic        bus_ADS_n;
    logic        bus_RD_n;
    logic        bus_WR_n;
    logic [11:0] bus_addr;
    logic [7:0]  bus_db_o;
    logic        bus_db_oe;
    logic [7:0]  bus_db_i;

    modport master (
        input  cyc_req, cyc_wr, cyc_addr, cyc_wdata, f_r, f_i, f_d, f_h,
        input  bus_ENIN, bus_NHOLD, bus_db_i,
        output cyc_ack, cyc_rdata, stall,
        output bus_BREQ, bus_ENOUT, bus_ADS_n, bus_RD_n, bus_WR_n,
        output bus_addr, bus_db_o, bus_db_oe
    );

    modport slave (
        output cyc_req, cyc_wr, cyc_addr, cyc_wdata, f_r, f_i, f_d, f_h,
        output bus_ENIN, bus_NHOLD, bus_db_i,
        input  cyc_ack, cyc_rdata, stall,
        input  bus_BREQ, bus_ENOUT, bus_ADS_n, bus_RD_n, bus_WR_n,
        input  bus_addr, bus_db_o, bus_db_oe
    );
endinterface

// File: rtl/scmp_bus_ctl.sv
// SC/MP external bus cycle controller: daisy-chain arbitration, NADS/NRDS/NWDS sequencing,
// NHOLD cycle extension and microcode stall.
module scmp_bus_ctl #(
    parameter int ADS_CYCLES  = 1,
    parameter int STRB_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    scmp_bus_if.master bus
);
    // state | meaning
    // IDLE  | no cycle, bus enable passes downstream
    // ARB   | BREQ raised, waiting for ENIN
    // ADDR  | NADS low, status flags and A15..A12 on data bus
    // STRB  | NRDS or NWDS low, NHOLD sampled on the final clock
    // DONE  | strobes released, cyc_ack pulsed
    typedef enum logic [2:0] {IDLE, ARB, ADDR, STRB, DONE} state_t;

    localparam logic [2:0] ADS_LOAD  = 3'(ADS_CYCLES - 1);
    localparam logic [2:0] STRB_LOAD = 3'(STRB_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        capture;
    logic        ads_n_q, rd_n_q, wr_n_q, breq_q, db_oe_q, ack_q;
    logic [11:0] addr_q;
    logic [7:0]  db_o_q, rdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: if (bus.cyc_req) state_d = ARB;
            ARB: begin
                if (!bus.cyc_req) begin
                    state_d = IDLE;
                end else if (bus.bus_ENIN) begin
                    state_d = ADDR;
                    cnt_d   = ADS_LOAD;
                end
            end
            ADDR: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    state_d = STRB;
                    cnt_d   = STRB_LOAD;
                end
            end
            STRB: begin
                // NHOLD only matters once the minimum strobe width has elapsed
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else if (bus.bus_NHOLD) begin
                    state_d = DONE;
                    capture = !bus.cyc_wr;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pin outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            ads_n_q <= 1'b1;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            breq_q  <= 1'b0;
            db_oe_q <= 1'b0;
            ack_q   <= 1'b0;
            addr_q  <= 12'd0;
            db_o_q  <= 8'd0;
            rdata_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ads_n_q <= !(state_d == ADDR);
            rd_n_q  <= !(state_d == STRB && !bus.cyc_wr);
            wr_n_q  <= !(state_d == STRB && bus.cyc_wr);
            breq_q  <= (state_d == ARB) || (state_d == ADDR) || (state_d == STRB);
            db_oe_q <= (state_d == ADDR) || (state_d == STRB && bus.cyc_wr);
            ack_q   <= (state_d == DONE);
            addr_q  <= (state_d == ADDR || state_d == STRB) ? bus.cyc_addr[11:0] : 12'd0;
            if (state_d == ADDR) begin
                db_o_q <= {bus.f_h, bus.f_d, bus.f_i, bus.f_r, bus.cyc_addr[15:12]};
            end else if (state_d == STRB && bus.cyc_wr) begin
                db_o_q <= bus.cyc_wdata;
            end else begin
                db_o_q <= 8'd0;
            end
            if (capture) rdata_q <= bus.bus_db_i;
        end
    end

    assign bus.bus_ENOUT = bus.bus_ENIN && (state_q == IDLE) && !bus.cyc_req;
    assign bus.stall     = bus.cyc_req && !ack_q;
    assign bus.cyc_ack   = ack_q;
    assign bus.cyc_rdata = rdata_q;
    assign bus.bus_BREQ  = breq_q;
    assign bus.bus_ADS_n = ads_n_q;
    assign bus.bus_RD_n  = rd_n_q;
    assign bus.bus_WR_n  = wr_n_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_db_o  = db_o_q;
    assign bus.bus_db_oe = db_oe_q;
endmodule

// File: tb/tb_scmp_bus_ctl.sv
// Directed bench for scmp_bus_ctl: one default instance and one with a 3-clock strobe,
// sharing stimulus; sel chooses which instance gets cyc_req and which one is observed.
module tb_scmp_bus_ctl;
    logic        clk = 1'b0;
    logic        rst_n, sel, req, wr, fr, fi, fd, fh, enin, nhold;
    logic [15:0] addr;
    logic [7:0]  wdata, db_i;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    scmp_bus_if if0();
    scmp_bus_if if1();

    assign if0.cyc_req   = req & ~sel;
    assign if1.cyc_req   = req & sel;
    assign if0.cyc_wr    = wr;
    assign if1.cyc_wr    = wr;
    assign if0.cyc_addr  = addr;
    assign if1.cyc_addr  = addr;
    assign if0.cyc_wdata = wdata;
    assign if1.cyc_wdata = wdata;
    assign if0.f_r = fr;
    assign if1.f_r = fr;
    assign if0.f_i = fi;
    assign if1.f_i = fi;
    assign if0.f_d = fd;
    assign if1.f_d = fd;
    assign if0.f_h = fh;
    assign if1.f_h = fh;
    assign if0.bus_ENIN  = enin;
    assign if1.bus_ENIN  = enin;
    assign if0.bus_NHOLD = nhold;
    assign if1.bus_NHOLD = nhold;
    assign if0.bus_db_i  = db_i;
    assign if1.bus_db_i  = db_i;

    scmp_bus_ctl dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.master));
    scmp_bus_ctl #(.ADS_CYCLES(1), .STRB_CYCLES(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));

    logic        m_ads, m_rd, m_wr, m_breq, m_oe, m_ack, m_enout, m_stall;
    logic [11:0] m_addr;
    logic [7:0]  m_dbo, m_rdata;
    assign m_ads   = sel ? if1.bus_ADS_n : if0.bus_ADS_n;
    assign m_rd    = sel ? if1.bus_RD_n  : if0.bus_RD_n;
    assign m_wr    = sel ? if1.bus_WR_n  : if0.bus_WR_n;
    assign m_breq  = sel ? if1.bus_BREQ  : if0.bus_BREQ;
    assign m_oe    = sel ? if1.bus_db_oe : if0.bus_db_oe;
    assign m_ack   = sel ? if1.cyc_ack   : if0.cyc_ack;
    assign m_enout = sel ? if1.bus_ENOUT : if0.bus_ENOUT;
    assign m_stall = sel ? if1.stall     : if0.stall;
    assign m_addr  = sel ? if1.bus_addr  : if0.bus_addr;
    assign m_dbo   = sel ? if1.bus_db_o  : if0.bus_db_o;
    assign m_rdata = sel ? if1.cyc_rdata : if0.cyc_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until cyc_ack (bounded), tallying strobe widths and what was on the bus.
    // hold_rel > 0 releases NHOLD and presents late_data right after that clock.
    task automatic run_cyc(input int max_k, input int hold_rel, input logic [7:0] late_data,
                           output int ack_at, output int ads_lo, output int rd_lo,
                           output int wr_lo, output int ovl, output logic [11:0] a_ads,
                           output logic [7:0] d_ads, output logic [7:0] d_wr,
                           output logic oe_wr);
        ack_at = -1; ads_lo = 0; rd_lo = 0; wr_lo = 0; ovl = 0;
        a_ads = 12'd0; d_ads = 8'd0; d_wr = 8'd0; oe_wr = 1'b0;
        for (int k = 1; k <= max_k; k++) begin
            step();
            if (!m_ads) begin
                ads_lo++;
                a_ads = m_addr;
                d_ads = m_dbo;
            end
            if (!m_rd) rd_lo++;
            if (!m_wr) begin
                wr_lo++;
                d_wr  = m_dbo;
                oe_wr = m_oe;
            end
            if (!m_ads && (!m_rd || !m_wr)) ovl++;
            if (m_ack) begin
                ack_at = k;
                break;
            end
            if (k == hold_rel) begin
                nhold = 1'b1;
                db_i  = late_data;
            end
        end
    endtask

    int          ack_at, ads_lo, rd_lo, wr_lo, ovl, first, second, idle_cnt;
    logic [11:0] a_ads;
    logic [7:0]  d_ads, d_wr;
    logic        oe_wr;

    initial begin
        rst_n = 1'b0; sel = 1'b0; req = 1'b0; wr = 1'b0; addr = 16'h0; wdata = 8'h0;
        db_i = 8'h0; fr = 1'b0; fi = 1'b0; fd = 1'b0; fh = 1'b0; enin = 1'b1; nhold = 1'b1;
        step();
        step();
        check("rst_ads", m_ads, 1);
        check("rst_rd", m_rd, 1);
        check("rst_wr", m_wr, 1);
        check("rst_breq", m_breq, 0);
        check("rst_oe", m_oe, 0);
        check("rst_addr", m_addr, 0);
        check("rst_dbo", m_dbo, 0);
        check("rst_ack", m_ack, 0);
        check("rst_rdata", m_rdata, 0);
        check("rst_enout", m_enout, 1);
        rst_n = 1'b1;
        step();

        // Default read, minimum latency
        addr = 16'h5A3C; fh = 1'b1; fd = 1'b0; fi = 1'b1; fr = 1'b0; db_i = 8'h7E; req = 1'b1;
        #1;
        check("rd_enout_req", m_enout, 0);
        check("rd_stall", m_stall, 1);
        run_cyc(20, 0, 8'h00, ack_at, ads_lo, rd_lo, wr_lo, ovl, a_ads, d_ads, d_wr, oe_wr);
        check("rd_ack_at", ack_at, 5);
        check("rd_ads_lo", ads_lo, 1);
        check("rd_rd_lo", rd_lo, 2);
        check("rd_wr_lo", wr_lo, 0);
        check("rd_overlap", ovl, 0);
        check("rd_ads_addr", a_ads, 12'hA3C);
        check("rd_ads_dbo", d_ads, 8'hA5);
        check("rd_rdata", m_rdata, 8'h7E);
        check("rd_stall_ack", m_stall, 0);
        req = 1'b0;
        step();

        // Arbitration: bus held by upstream for 4 clocks
        fh = 1'b0; fi = 1'b0; enin = 1'b0; addr = 16'h1234; db_i = 8'h55; req = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("arb_breq", m_breq, 1);
            check("arb_ads", m_ads, 1);
            check("arb_rd", m_rd, 1);
            check("arb_enout", m_enout, 0);
        end
        enin = 1'b1;
        run_cyc(20, 0, 8'h00, ack_at, ads_lo, rd_lo, wr_lo, ovl, a_ads, d_ads, d_wr, oe_wr);
        check("arb_ack_at", ack_at, 4);
        check("arb_ads_lo", ads_lo, 1);
        check("arb_ads_addr", a_ads, 12'h234);
        check("arb_rdata", m_rdata, 8'h55);
        req = 1'b0;
        step();
        check("idle_enout_hi", m_enout, 1);
        enin = 1'b0;
        #1;
        check("idle_enout_lo", m_enout, 0);
        enin = 1'b1;

        // NHOLD extends the final strobe clock three times
        nhold = 1'b0; db_i = 8'h11; addr = 16'h0200; req = 1'b1;
        run_cyc(20, 7, 8'h96, ack_at, ads_lo, rd_lo, wr_lo, ovl, a_ads, d_ads, d_wr, oe_wr);
        check("hold_ack_at", ack_at, 8);
        check("hold_rd_lo", rd_lo, 5);
        check("hold_rdata", m_rdata, 8'h96);
        req = 1'b0;
        step();

        // STRB_CYCLES=3 instance: read to seed cyc_rdata, then a write
        sel = 1'b1; wr = 1'b0; addr = 16'h0300; db_i = 8'h3C; req = 1'b1;
        run_cyc(20, 0, 8'h00, ack_at, ads_lo, rd_lo, wr_lo, ovl, a_ads, d_ads, d_wr, oe_wr);
        check("s3rd_ack_at", ack_at, 6);
        check("s3rd_rd_lo", rd_lo, 3);
        check("s3rd_rdata", m_rdata, 8'h3C);
        req = 1'b0;
        step();
        wr = 1'b1; addr = 16'h0010; wdata = 8'hC3; db_i = 8'hEE; req = 1'b1;
        run_cyc(20, 0, 8'h00, ack_at, ads_lo, rd_lo, wr_lo, ovl, a_ads, d_ads, d_wr, oe_wr);
        check("wr_ack_at", ack_at, 6);
        check("wr_wr_lo", wr_lo, 3);
        check("wr_rd_lo", rd_lo, 0);
        check("wr_overlap", ovl, 0);
        check("wr_dbo", d_wr, 8'hC3);
        check("wr_oe", oe_wr, 1);
        check("wr_ads_addr", a_ads, 12'h010);
        check("wr_ads_dbo", d_ads, 8'h00);
        check("wr_rdata_kept", m_rdata, 8'h3C);
        req = 1'b0;
        step();
        sel = 1'b0;

        // Reset in the middle of a write strobe
        wr = 1'b1; addr = 16'h0F00; wdata = 8'h5C; req = 1'b1;
        step();
        step();
        step();
        check("mid_wr_low", m_wr, 0);
        rst_n = 1'b0;
        step();
        check("mrst_ads", m_ads, 1);
        check("mrst_rd", m_rd, 1);
        check("mrst_wr", m_wr, 1);
        check("mrst_oe", m_oe, 0);
        check("mrst_breq", m_breq, 0);
        check("mrst_ack", m_ack, 0);
        check("mrst_rdata", m_rdata, 0);
        rst_n = 1'b1; req = 1'b0;
        step();
        wr = 1'b0; addr = 16'h0042; db_i = 8'h42; req = 1'b1;
        run_cyc(20, 0, 8'h00, ack_at, ads_lo, rd_lo, wr_lo, ovl, a_ads, d_ads, d_wr, oe_wr);
        check("post_rst_ack_at", ack_at, 5);
        check("post_rst_rdata", m_rdata, 8'h42);
        req = 1'b0;
        step();

        // Back-to-back reads with cyc_req held
        addr = 16'h0100; db_i = 8'h21; req = 1'b1;
        first = 0; second = 0; idle_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (m_ack) begin
                if (first == 0) begin
                    first = k;
                    check("b2b_rdata1", m_rdata, 8'h21);
                    db_i = 8'h22;
                end else begin
                    second = k;
                    break;
                end
            end else if (first != 0 && !m_breq) begin
                idle_cnt++;
            end
        end
        check("b2b_first", first, 5);
        check("b2b_gap", second - first, 6);
        check("b2b_idle", idle_cnt, 1);
        check("b2b_rdata2", m_rdata, 8'h22);
        req = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
